// File: rtl/clock_switch_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : clock_switch_seq_if
// Purpose  : Request handshake, clk_sel drive and status bundle for the
//            clock-switch sequencer.
// Revision : 1.0 - initial release
// ============================================================================

interface clock_switch_seq_if;
    logic       req_valid;
    logic [1:0] req_sel;
    logic       req_ready;
    logic [1:0] clk_sel;
    logic       mon_toggle;
    logic       busy;
    logic       done;
    logic       err;

    // master: the requesting agent (also supplies the synchronized monitor)
    modport master (
        output req_valid, req_sel, mon_toggle,
        input  req_ready, clk_sel, busy, done, err
    );

    // slave: the sequencer itself
    modport slave (
        input  req_valid, req_sel, mon_toggle,
        output req_ready, clk_sel, busy, done, err
    );
endinterface

`default_nettype wire

// File: rtl/clock_switch_seq.sv
`default_nettype none
// ============================================================================
// Module   : clock_switch_seq
// Purpose  : Steps clk_sel of the 3-source glitch-free clock switch one bit at
//            a time, settles after each step and verifies the new clock.
// Revision : 1.0 - initial release
// ============================================================================

module clock_switch_seq #(
    parameter int SETTLE_CYC  = 16,
    parameter int MIN_TOGGLES = 4,
    parameter int TIMEOUT_CYC = 256
) (
    input  wire logic         clk,
    input  wire logic         rst,
    clock_switch_seq_if.slave sw
);

    localparam int c_CNT_MAX = (SETTLE_CYC > TIMEOUT_CYC) ? SETTLE_CYC : TIMEOUT_CYC;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

    localparam logic [c_CNT_W-1:0] c_ONE         = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_SETTLE_LAST = c_CNT_W'(SETTLE_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_TMO_LAST    = c_CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_MIN_TOG     = c_CNT_W'(MIN_TOGGLES);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_STEP1   = 3'd1;
    localparam logic [2:0] c_SETTLE1 = 3'd2;
    localparam logic [2:0] c_STEP2   = 3'd3;
    localparam logic [2:0] c_SETTLE2 = 3'd4;
    localparam logic [2:0] c_VERIFY  = 3'd5;
    localparam logic [2:0] c_FIN     = 3'd6;

    logic [2:0]         r_state;
    logic [2:0]         w_state_next;
    logic [1:0]         r_clk_sel;
    logic [1:0]         r_target;
    logic               r_two_step;
    logic               r_err;
    logic               r_mon_prev;
    logic [c_CNT_W-1:0] r_settle_cnt;
    logic [c_CNT_W-1:0] r_tog_cnt;
    logic [c_CNT_W-1:0] r_tmo_cnt;

    logic               w_accept;
    logic               w_edge;
    logic               w_in_settle;
    logic               w_settle_last;
    logic [c_CNT_W-1:0] w_tog_sum;
    logic               w_tog_hit;
    logic               w_tmo_hit;
    logic               w_req_ready;
    logic               w_busy;
    logic               w_done;
    logic               w_err;

    assign w_accept      = sw.req_valid && w_req_ready;
    assign w_edge        = sw.mon_toggle ^ r_mon_prev;
    assign w_in_settle   = (r_state == c_SETTLE1) || (r_state == c_SETTLE2);
    assign w_settle_last = (r_settle_cnt == c_SETTLE_LAST);
    assign w_tog_sum     = r_tog_cnt + {{(c_CNT_W-1){1'b0}}, w_edge};
    assign w_tog_hit     = (w_tog_sum >= c_MIN_TOG);
    assign w_tmo_hit     = (r_tmo_cnt == c_TMO_LAST);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_accept) begin
                    w_state_next = (sw.req_sel == r_clk_sel) ? c_FIN : c_STEP1;
                end
            end
            c_STEP1:   w_state_next = c_SETTLE1;
            c_SETTLE1: begin
                if (w_settle_last) begin
                    w_state_next = r_two_step ? c_STEP2 : c_VERIFY;
                end
            end
            c_STEP2:   w_state_next = c_SETTLE2;
            c_SETTLE2: begin
                if (w_settle_last) begin
                    w_state_next = c_VERIFY;
                end
            end
            c_VERIFY: begin
                if (w_tog_hit || w_tmo_hit) begin
                    w_state_next = c_FIN;
                end
            end
            c_FIN:     w_state_next = c_IDLE;
            default:   w_state_next = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_req_ready = (r_state == c_IDLE);
        w_busy      = (r_state != c_IDLE);
        w_done      = (r_state == c_FIN);
        w_err       = (r_state == c_FIN) && r_err;
    end

    assign sw.req_ready = w_req_ready;
    assign sw.busy      = w_busy;
    assign sw.done      = w_done;
    assign sw.err       = w_err;
    assign sw.clk_sel   = r_clk_sel;

    // ------------------------------------------------------------------
    // Datapath: select register, request latch, counters, monitor edge
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_clk_sel    <= 2'b00;
            r_target     <= 2'b00;
            r_two_step   <= 1'b0;
            r_err        <= 1'b0;
            r_mon_prev   <= 1'b0;
            r_settle_cnt <= '0;
            r_tog_cnt    <= '0;
            r_tmo_cnt    <= '0;
        end else begin
            r_mon_prev <= sw.mon_toggle;

            if (w_accept) begin
                r_target   <= sw.req_sel;
                r_two_step <= sw.req_sel[1] ^ r_clk_sel[1];
                r_err      <= 1'b0;
            end

            // Going up, sel[1] moves first so the sel[0] change happens
            // behind the 1000M source; going down, sel[0] moves first.
            case (r_state)
                c_STEP1: begin
                    if (r_target[1] && !r_clk_sel[1]) begin
                        r_clk_sel[1] <= 1'b1;
                    end else begin
                        r_clk_sel[0] <= r_target[0];
                    end
                end
                c_STEP2: r_clk_sel <= r_target;
                default: ;
            endcase

            r_settle_cnt <= (w_in_settle && !w_settle_last) ? (r_settle_cnt + c_ONE) : '0;

            if (r_state == c_VERIFY) begin
                if (r_tog_cnt != c_MIN_TOG) begin
                    r_tog_cnt <= w_tog_sum;
                end
                if (!w_tmo_hit) begin
                    r_tmo_cnt <= r_tmo_cnt + c_ONE;
                end
                // Success takes priority when both terminate together
                if (w_tog_hit || w_tmo_hit) begin
                    r_err <= !w_tog_hit;
                end
            end else begin
                r_tog_cnt <= '0;
                r_tmo_cnt <= '0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_clock_switch_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_clock_switch_seq
// Purpose  : Directed and randomized checks of clock_switch_seq against a
//            cycle-timeline reference derived from the switching rules.
// Revision : 1.0 - initial release
// ============================================================================

module tb_clock_switch_seq;

    localparam int c_S   = 16;
    localparam int c_MIN = 4;
    localparam int c_TMO = 256;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [1:0] model_sel = 2'b00;
    logic       mon_arr [0:399];

    clock_switch_seq_if u_if ();

    clock_switch_seq #(
        .SETTLE_CYC  (c_S),
        .MIN_TOGGLES (c_MIN),
        .TIMEOUT_CYC (c_TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .sw  (u_if)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk1({tag, " ready"}, u_if.req_ready, 1'b1);
        chk1({tag, " busy"},  u_if.busy,      1'b0);
        chk1({tag, " done"},  u_if.done,      1'b0);
        chk1({tag, " err"},   u_if.err,       1'b0);
        chk2({tag, " sel"},   u_if.clk_sel,   model_sel);
    endtask

    task automatic idle_cycles(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            chk_idle($sformatf("%s idle%0d", tag, i));
        end
    endtask

    task automatic do_reset(input int ncyc);
        rst = 1'b1;
        u_if.req_valid = 1'b1;
        repeat (ncyc) @(posedge clk);
        #1;
        model_sel = 2'b00;
        chk_idle("reset");
        rst = 1'b0;
        u_if.req_valid = 1'b0;
        idle_cycles(2, "post_reset");
    endtask

    // One request accepted at edge k=0; checks every cycle up to return to
    // IDLE. abort_k >= 0 asserts rst for the edge numbered abort_k.
    task automatic run_req(input logic [1:0] tgt, input int period, input int phase,
                           input int abort_k, input string name);
        logic [1:0] cur, mid, exp_sel;
        bit         same, two, exp_err, aborted;
        int         v, d, cnt;
        cur     = model_sel;
        same    = (tgt == cur);
        two     = (tgt[1] != cur[1]);
        mid     = (tgt[1] && !cur[1]) ? {1'b1, cur[0]} : {cur[1], tgt[0]};
        v       = two ? (2 + 2 * c_S) : (1 + c_S);
        aborted = 1'b0;
        for (int k = 0; k < 400; k++) begin
            mon_arr[k] = (period == 0) ? phase[0] : ((((k + phase) / period) % 2) == 1);
        end
        if (same) begin
            d       = 0;
            exp_err = 1'b0;
        end else begin
            d       = v + c_TMO;
            exp_err = 1'b1;
            cnt     = 0;
            for (int e = v + 1; e <= v + c_TMO; e++) begin
                if (mon_arr[e] != mon_arr[e-1]) cnt++;
                if (cnt >= c_MIN) begin
                    d       = e;
                    exp_err = 1'b0;
                    break;
                end
            end
        end

        chk1({name, " ready_pre"}, u_if.req_ready, 1'b1);
        u_if.req_valid  = 1'b1;
        u_if.req_sel    = tgt;
        u_if.mon_toggle = mon_arr[0];
        for (int k = 0; k <= d + 1; k++) begin
            if (k == abort_k) rst = 1'b1;
            @(posedge clk); #1;
            u_if.req_valid  = (k <= d) ? 1'($urandom_range(0, 1)) : 1'b0;
            u_if.req_sel    = 2'($urandom_range(0, 3));
            u_if.mon_toggle = mon_arr[k+1];
            if (k == abort_k) begin
                rst            = 1'b0;
                u_if.req_valid = 1'b0;
                model_sel      = 2'b00;
                chk_idle($sformatf("%s abort k=%0d", name, k));
                aborted = 1'b1;
                break;
            end
            if (same || k == 0)        exp_sel = cur;
            else if (two && k <= 1 + c_S) exp_sel = mid;
            else                        exp_sel = tgt;
            chk2($sformatf("%s sel k=%0d", name, k),   u_if.clk_sel,   exp_sel);
            chk1($sformatf("%s busy k=%0d", name, k),  u_if.busy,      k <= d);
            chk1($sformatf("%s ready k=%0d", name, k), u_if.req_ready, k > d);
            chk1($sformatf("%s done k=%0d", name, k),  u_if.done,      k == d);
            chk1($sformatf("%s err k=%0d", name, k),   u_if.err,       (k == d) && exp_err);
        end
        if (!aborted) model_sel = tgt;
    endtask

    initial begin
        u_if.req_valid  = 1'b0;
        u_if.req_sel    = 2'b00;
        u_if.mon_toggle = 1'b0;

        do_reset(3);

        run_req(2'b01, 3, 0, -1, "up_00_01");
        run_req(2'b00, 2, 1, -1, "dn_01_00");
        run_req(2'b11, 3, 0, -1, "up_00_11");
        run_req(2'b01, 4, 2, -1, "dn_11_01");
        run_req(2'b10, 3, 0, -1, "up_01_10");
        run_req(2'b00, 5, 0, -1, "dn_10_00");
        run_req(2'b01, 0, 1, -1, "timeout_00_01");
        idle_cycles(1, "after_timeout");
        run_req(2'b01, 3, 0, -1, "same_01");
        run_req(2'b00, 3, 0, -1, "back_00");
        run_req(2'b11, 3, 0, 2 + c_S + 6, "abort_00_11");
        idle_cycles(4, "after_abort");
        run_req(2'b10, 2, 0, -1, "post_abort_00_10");
        run_req(2'b11, 1, 0, -1, "hi_10_11");

        for (int i = 0; i < 24; i++) begin
            int p;
            p = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 6));
            run_req(2'($urandom_range(0, 3)), p, int'($urandom_range(0, 5)), -1,
                    $sformatf("rnd%0d", i));
            idle_cycles(int'($urandom_range(0, 2)), $sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
